// File: rtl/render_dispatcher.sv
// Raster-order pixel dispatcher over NUM_LANES raymarchers plus a single-port frame-buffer write arbiter.
// Start pulse 2 cycles after reset, write 2 cycles after done; enable_in stalls dispatch only, lanes are never backpressured.
module render_dispatcher #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_LANES = 3,
  parameter int BITS      = 32,
  parameter int CAM_W     = 12*BITS,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH*HEIGHT),
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic [CAM_W-1:0]        cam_raw_in,
  output logic [CAM_W-1:0]        cam_out,
  output logic [31:0]             timer_out,
  output logic [NUM_LANES-1:0]    lane_start_out,
  output logic [XW-1:0]           pix_x_out,
  output logic [YW-1:0]           pix_y_out,
  input  logic [NUM_LANES-1:0]    lane_done_in,
  input  logic [8*NUM_LANES-1:0]  lane_color_in,
  input  logic [XW*NUM_LANES-1:0] lane_x_in,
  input  logic [YW*NUM_LANES-1:0] lane_y_in,
  output logic                    fb_we_out,
  output logic [AW-1:0]           fb_addr_out,
  output logic [7:0]              fb_data_out,
  output logic                    frame_done_out,
  output logic                    err_out
);

  localparam logic [31:0] WIDTH_U  = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_U = 32'(HEIGHT);

  typedef enum logic [1:0] {LATCH, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [7:0]    color;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } res_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        dp_q, dp_d, wp_q, wp_d;
  logic [XW-1:0]        cur_x_q, cur_x_d, pix_x_q, pix_x_d;
  logic [YW-1:0]        cur_y_q, cur_y_d, pix_y_q, pix_y_d;
  logic [NUM_LANES-1:0] busy_q, busy_d, pend_q, pend_d, start_q, start_d;
  res_t                 res_q [NUM_LANES];
  res_t                 res_d [NUM_LANES];
  logic [CAM_W-1:0]     cam_q, cam_d;
  logic [31:0]          timer_q, timer_d;
  logic                 fb_we_q, fb_we_d;
  logic [AW-1:0]        fb_addr_q, fb_addr_d;
  logic [7:0]           fb_data_q, fb_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_q, err_d;
  logic                 ds_found, wr_found;
  int                   ds_sel, wr_sel;

  function automatic int rot(input int base, input int off);
    return (base + off) % NUM_LANES;
  endfunction

  always_comb begin
    state_d      = state_q;
    dp_d         = dp_q;
    wp_d         = wp_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    busy_d       = busy_q;
    pend_d       = pend_q;
    start_d      = '0;
    res_d        = res_q;
    cam_d        = cam_q;
    timer_d      = timer_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    ds_found     = 1'b0;
    ds_sel       = 0;
    wr_found     = 1'b0;
    wr_sel       = 0;

    // Capture: out-of-range results are kept but never queued for writing.
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_done_in[k]) begin
        if (!busy_q[k]) begin
          err_d = 1'b1;
        end else begin
          res_d[k].color = lane_color_in[8*k +: 8];
          res_d[k].x     = lane_x_in[XW*k +: XW];
          res_d[k].y     = lane_y_in[YW*k +: YW];
          busy_d[k]      = 1'b0;
          if (32'(lane_x_in[XW*k +: XW]) < WIDTH_U && 32'(lane_y_in[YW*k +: YW]) < HEIGHT_U)
            pend_d[k] = 1'b1;
          else
            err_d = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      if (!wr_found && pend_q[rot(int'(wp_q), i)]) begin
        wr_found = 1'b1;
        wr_sel   = rot(int'(wp_q), i);
      end
    end
    if (wr_found) begin
      pend_d[wr_sel] = 1'b0;
      fb_we_d        = 1'b1;
      fb_addr_d      = AW'(32'(res_q[wr_sel].x) + WIDTH_U * 32'(res_q[wr_sel].y));
      fb_data_d      = res_q[wr_sel].color;
      wp_d           = LW'(rot(wr_sel, 1));
    end

    case (state_q)
      LATCH: begin
        cam_d   = cam_raw_in;
        cur_x_d = '0;
        cur_y_d = '0;
        state_d = RUN;
      end
      RUN: begin
        if (enable_in) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (!ds_found && !busy_q[rot(int'(dp_q), i)] && !pend_q[rot(int'(dp_q), i)]) begin
              ds_found = 1'b1;
              ds_sel   = rot(int'(dp_q), i);
            end
          end
        end
        if (ds_found) begin
          start_d[ds_sel] = 1'b1;
          busy_d[ds_sel]  = 1'b1;
          pix_x_d         = cur_x_q;
          pix_y_d         = cur_y_q;
          dp_d            = LW'(rot(ds_sel, 1));
          if (cur_x_q == XW'(WIDTH-1)) begin
            cur_x_d = '0;
            if (cur_y_q == YW'(HEIGHT-1)) begin
              cur_y_d = '0;
              state_d = DRAIN;
            end else begin
              cur_y_d = cur_y_q + 1'b1;
            end
          end else begin
            cur_x_d = cur_x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (busy_q == '0 && pend_q == '0 && !fb_we_q) begin
          frame_done_d = 1'b1;
          timer_d      = timer_q + 32'd1;
          state_d      = LATCH;
        end
      end
      default: state_d = LATCH;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= LATCH;
      dp_q         <= '0;
      wp_q         <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      busy_q       <= '0;
      pend_q       <= '0;
      start_q      <= '0;
      for (int k = 0; k < NUM_LANES; k++) res_q[k] <= '0;
      cam_q        <= '0;
      timer_q      <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dp_q         <= dp_d;
      wp_q         <= wp_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      start_q      <= start_d;
      res_q        <= res_d;
      cam_q        <= cam_d;
      timer_q      <= timer_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign cam_out        = cam_q;
  assign timer_out      = timer_q;
  assign lane_start_out = start_q;
  assign pix_x_out      = pix_x_q;
  assign pix_y_out      = pix_y_q;
  assign fb_we_out      = fb_we_q;
  assign fb_addr_out    = fb_addr_q;
  assign fb_data_out    = fb_data_q;
  assign frame_done_out = frame_done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_render_dispatcher.sv
// Bench for render_dispatcher on a 4x2 frame with three behavioural lanes returning a random per-pixel color table.
module tb_render_dispatcher;
  localparam int W = 4, H = 2, N = 3, BITS = 8, CAM_W = 12*BITS;
  localparam int XW = 2, YW = 1, AW = 3, NPIX = W*H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, en = 1'b0;
  logic [CAM_W-1:0]  cam_raw = '0, cam_out;
  logic [31:0]       timer_out;
  logic [N-1:0]      lane_start, lane_done = '0;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic [8*N-1:0]    lane_color = '0;
  logic [XW*N-1:0]   lane_x = '0;
  logic [YW*N-1:0]   lane_y = '0;
  logic              fb_we, frame_done, err;
  logic [AW-1:0]     fb_addr;
  logic [7:0]        fb_data;

  render_dispatcher #(.WIDTH(W), .HEIGHT(H), .NUM_LANES(N), .BITS(BITS), .CAM_W(CAM_W)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .cam_raw_in(cam_raw), .cam_out(cam_out),
    .timer_out(timer_out), .lane_start_out(lane_start), .pix_x_out(pix_x), .pix_y_out(pix_y),
    .lane_done_in(lane_done), .lane_color_in(lane_color), .lane_x_in(lane_x), .lane_y_in(lane_y),
    .fb_we_out(fb_we), .fb_addr_out(fb_addr), .fb_data_out(fb_data),
    .frame_done_out(frame_done), .err_out(err));

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane model: fixed latency per lane, or held while stalled; color comes from tbl[x + W*y].
  logic [7:0]   tbl [NPIX];
  int           lat [N];
  logic [N-1:0] stall = '0;
  int           cnt [N];
  bit           held [N];
  int           px [N], py [N];
  int           inj_seq = 0, inj_ack = 0;

  always @(negedge clk) begin
    logic [N-1:0] dv;
    dv = '0;
    if (rst) begin
      for (int k = 0; k < N; k++) begin cnt[k] = 0; held[k] = 0; end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (cnt[k] == 1) dv[k] = 1'b1;
        if (cnt[k] > 0) cnt[k]--;
        if (held[k] && !stall[k]) begin dv[k] = 1'b1; held[k] = 0; end
      end
      if (inj_seq != inj_ack) begin dv[2] = 1'b1; inj_ack = inj_seq; end
      for (int k = 0; k < N; k++) begin
        if (lane_start[k]) begin
          px[k] = int'(pix_x); py[k] = int'(pix_y);
          if (stall[k]) held[k] = 1; else cnt[k] = lat[k];
        end
      end
    end
    lane_done = dv;
    for (int k = 0; k < N; k++) begin
      lane_color[8*k +: 8] = tbl[px[k] + W*py[k]];
      lane_x[XW*k +: XW]   = XW'(px[k]);
      lane_y[YW*k +: YW]   = YW'(py[k]);
    end
  end

  // Observation log, cleared while reset is held.
  int wr_cnt [NPIX];
  int n_wr, n_start, n_fd, bad_data, bad_onehot;
  int wr_addr_q[$], wr_cyc_q[$], st_lane_q[$];

  always @(negedge clk) begin
    int sl;
    if (rst) begin
      for (int a = 0; a < NPIX; a++) wr_cnt[a] = 0;
      n_wr = 0; n_start = 0; n_fd = 0; bad_data = 0; bad_onehot = 0;
      wr_addr_q.delete(); wr_cyc_q.delete(); st_lane_q.delete();
    end else begin
      if (fb_we) begin
        n_wr++;
        wr_cnt[fb_addr]++;
        if (fb_data !== tbl[fb_addr]) bad_data++;
        wr_addr_q.push_back(int'(fb_addr));
        wr_cyc_q.push_back(cyc);
      end
      if (lane_start != '0) begin
        sl = 0;
        for (int k = 0; k < N; k++) if (lane_start[k]) sl = k;
        if ($countones(lane_start) != 1) bad_onehot++;
        n_start++;
        st_lane_q.push_back(sl);
      end
      if (frame_done) n_fd++;
    end
  end

  task automatic do_reset(input bit en_after, input logic [N-1:0] stall_v, output int rel);
    rst = 1'b1; en = 1'b0; stall = stall_v;
    for (int a = 0; a < NPIX; a++) tbl[a] = 8'($urandom);
    cam_raw = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    en = en_after; rst = 1'b0; rel = cyc;
  endtask

  task automatic wait_fd(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1; break; end
    end
  endtask

  task automatic rand_lat();
    for (int k = 0; k < N; k++) lat[k] = $urandom_range(1, 8);
  endtask

  task automatic test_reset();
    int rel;
    rand_lat();
    rst = 1'b1; en = 1'b1; cam_raw = {$urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    checks++; if (cam_out !== '0) begin failures++; $display("FAIL reset_cam: got %h expected 0", cam_out); end
    checks++; if (timer_out !== 32'd0) begin failures++; $display("FAIL reset_timer: got %0d expected 0", timer_out); end
    checks++; if ({lane_start, fb_we, frame_done, err} !== '0) begin failures++;
      $display("FAIL reset_ctrl: got start=%b we=%b fd=%b err=%b expected all 0", lane_start, fb_we, frame_done, err); end
    checks++; if ({pix_x, pix_y, fb_addr, fb_data} !== '0) begin failures++;
      $display("FAIL reset_data: got x=%0d y=%0d addr=%0d data=%0d expected 0", pix_x, pix_y, fb_addr, fb_data); end
    do_reset(1'b1, '0, rel);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lane_start !== '0) break;
    end
    checks++; if (cyc - rel != 2) begin failures++; $display("FAIL first_start_latency: got %0d expected 2", cyc - rel); end
    checks++; if ({lane_start, pix_x, pix_y} !== {3'b001, 2'd0, 1'b0}) begin failures++;
      $display("FAIL first_start: got lanes=%b x=%0d y=%0d expected lanes=001 x=0 y=0", lane_start, pix_x, pix_y); end
    checks++; if (cam_out !== cam_raw) begin failures++; $display("FAIL cam_latch: got %h expected %h", cam_out, cam_raw); end
  endtask

  task automatic check_all_once(input string nm);
    for (int a = 0; a < NPIX; a++) begin
      checks++; if (wr_cnt[a] != 1) begin failures++; $display("FAIL %s_addr%0d: got %0d writes expected 1", nm, a, wr_cnt[a]); end
    end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL %s_data: got %0d wrong bytes expected 0", nm, bad_data); end
  endtask

  task automatic test_frame();
    bit seen;
    wait_fd(400, seen);
    en = 1'b0;
    @(negedge clk);
    checks++; if (!seen) begin failures++; $display("FAIL frame_done_seen: got 0 expected 1"); end
    checks++; if (timer_out !== 32'd1) begin failures++; $display("FAIL frame_timer: got %0d expected 1", timer_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL frame_err: got %b expected 0", err); end
    checks++; if (n_fd != 1) begin failures++; $display("FAIL frame_done_count: got %0d expected 1", n_fd); end
    checks++; if (n_start != NPIX || bad_onehot != 0) begin failures++;
      $display("FAIL frame_starts: got %0d starts %0d non-onehot expected 8 and 0", n_start, bad_onehot); end
    check_all_once("frame");
  endtask

  task automatic test_same_cycle();
    int rel; bit seen;
    for (int k = 0; k < N; k++) lat[k] = 6;
    do_reset(1'b1, 3'b111, rel);
    for (int i = 0; i < 20 && n_start < 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    stall = '0;
    wait_fd(300, seen);
    en = 1'b0;
    @(negedge clk);
    checks++; if (!seen) begin failures++; $display("FAIL same_cycle_done: got 0 expected 1"); end
    checks++;
    if (wr_addr_q.size() < 3) begin failures++; $display("FAIL same_cycle_writes: got %0d expected >=3", wr_addr_q.size()); end
    else begin
      for (int j = 0; j < 3; j++) begin
        checks++; if (wr_addr_q[j] != j) begin failures++; $display("FAIL same_cycle_order%0d: got addr %0d expected %0d", j, wr_addr_q[j], j); end
      end
      checks++; if (wr_cyc_q[1] - wr_cyc_q[0] != 1 || wr_cyc_q[2] - wr_cyc_q[0] != 2) begin failures++;
        $display("FAIL same_cycle_b2b: got gaps %0d,%0d expected 1,2", wr_cyc_q[1] - wr_cyc_q[0], wr_cyc_q[2] - wr_cyc_q[0]); end
    end
    check_all_once("same_cycle");
  endtask

  task automatic test_stall_lane1();
    int rel, l1; bit seen;
    for (int k = 0; k < N; k++) lat[k] = 4;
    do_reset(1'b1, 3'b010, rel);
    for (int i = 0; i < 100 && n_start < NPIX; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    l1 = 0;
    foreach (st_lane_q[j]) if (st_lane_q[j] == 1) l1++;
    checks++; if (n_start != NPIX) begin failures++; $display("FAIL stall_starts: got %0d expected 8", n_start); end
    checks++; if (l1 != 1) begin failures++; $display("FAIL stall_lane1_starts: got %0d expected 1", l1); end
    checks++; if (n_fd != 0) begin failures++; $display("FAIL stall_drain_hold: got %0d frame_done expected 0", n_fd); end
    checks++; if (n_wr != NPIX-1) begin failures++; $display("FAIL stall_writes: got %0d expected 7", n_wr); end
    stall = '0;
    wait_fd(20, seen);
    en = 1'b0;
    @(negedge clk);
    checks++; if (!seen) begin failures++; $display("FAIL stall_release_done: got 0 expected 1"); end
    check_all_once("stall");
  endtask

  task automatic test_cam();
    int rel, cam_bad; bit seen;
    logic [CAM_W-1:0] a, b;
    rand_lat();
    do_reset(1'b1, '0, rel);
    a = cam_raw;
    for (int i = 0; i < 30 && n_start < 3; i++) @(negedge clk);
    b = ~a ^ {$urandom, $urandom, $urandom} & {CAM_W{1'b0}};
    cam_raw = b;
    cam_bad = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cam_out !== a) cam_bad++;
      if (frame_done) begin seen = 1; break; end
    end
    en = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL cam_frame_done: got 0 expected 1"); end
    checks++; if (cam_bad != 0) begin failures++; $display("FAIL cam_hold: got %0d changed cycles expected 0", cam_bad); end
    @(negedge clk);
    checks++; if (cam_out !== b) begin failures++; $display("FAIL cam_update: got %h expected %h", cam_out, b); end
  endtask

  task automatic test_enable();
    int rel, k, st_in, we_in; bit seen;
    for (int j = 0; j < N; j++) lat[j] = 5;
    do_reset(1'b1, '0, rel);
    k = 0;
    for (int i = 0; i < 50 && k < 4; i++) begin
      @(negedge clk);
      if (lane_start != '0) k++;
    end
    en = 1'b0; st_in = 0; we_in = 0;
    repeat (10) begin
      @(negedge clk);
      if (lane_start != '0) st_in++;
      if (fb_we) we_in++;
    end
    en = 1'b1;
    checks++; if (st_in != 0) begin failures++; $display("FAIL enable_low_starts: got %0d expected 0", st_in); end
    checks++; if (we_in == 0) begin failures++; $display("FAIL enable_low_drain: got 0 writes expected >0"); end
    wait_fd(300, seen);
    en = 1'b0;
    @(negedge clk);
    checks++; if (!seen || n_fd != 1) begin failures++; $display("FAIL enable_frame_done: got %0d expected 1", n_fd); end
    check_all_once("enable");
  endtask

  task automatic test_spurious();
    int rel;
    do_reset(1'b0, '0, rel);
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL spur_pre_err: got %b expected 0", err); end
    inj_seq++;
    repeat (6) @(negedge clk);
    checks++; if (n_wr != 0) begin failures++; $display("FAIL spur_no_write: got %0d expected 0", n_wr); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL spur_err: got %b expected 1", err); end
    repeat (10) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL spur_err_sticky: got %b expected 1", err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL spur_err_reset: got %b expected 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_timer();
    int rel; bit s1, s2;
    rand_lat();
    do_reset(1'b1, '0, rel);
    wait_fd(400, s1);
    checks++; if (!s1 || timer_out !== 32'd1) begin failures++; $display("FAIL timer_first: got %0d expected 1", timer_out); end
    wait_fd(400, s2);
    en = 1'b0;
    checks++; if (!s2 || timer_out !== 32'd2) begin failures++; $display("FAIL timer_second: got %0d expected 2", timer_out); end
    @(negedge clk);
    for (int a = 0; a < NPIX; a++) begin
      checks++; if (wr_cnt[a] != 2) begin failures++; $display("FAIL timer_addr%0d: got %0d writes expected 2", a, wr_cnt[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_same_cycle();
    test_stall_lane1();
    test_cam();
    test_enable();
    test_spurious();
    test_timer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
